nes_cpu_mem_ctrl: RTL
=====================

Name: nes_cpu_mem_ctrl

Overview:
Parametrised successor to the CPU-side memory model. It decodes the 16-bit CPU address map into internal ROM, 2 KB-mirrored RAM, SRAM and 8-entry I/O register storage. It adds a sprite DMA engine at $4014 that stalls the CPU and writes 256 bytes to an OAM port. It also emulates NUM_JOYPADS serial joypad shift registers at $4016/$4017. It sits between the CPU core and the PPU/OAM in the top level.

Parameters:
ROM_AW, 15, ROM address width; ROM occupies $8000-$FFFF, indexed by addr[ROM_AW-1:0].
RAM_AW, 11, internal RAM address width; mirrored across $0000-$1FFF.
SRAM_AW, 13, cartridge SRAM address width at $6000-$7FFF.
NUM_JOYPADS, 2, joypad channels (1..2); pad0 at $4016, pad1 at $4017.
DMA_LEN, 256, bytes per sprite DMA.

Ports:
clk  in  1  system clock
b_rst  in  1  asynchronous active-low reset
ren  in  1  CPU read strobe; one read per cycle high
wen  in  1  CPU write strobe
cpu_addr  in  16  CPU address
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  read data, combinational in the same cycle as ren
cpu_rdy  out  1  0 stalls the CPU (DMA in progress)
oam_wen  out  1  OAM write strobe
oam_waddr  out  8  OAM byte index
oam_wdata  out  8  OAM write data
joy_buttons  in  8*NUM_JOYPADS  live button state, pad n in [8n+7:8n], bit0=A ... bit7=Right
rom_ld_en  in  1  ROM preload write (reset or idle only)
rom_ld_addr  in  ROM_AW  preload address
rom_ld_data  in  8  preload data
rom_wr_err  out  1  one-cycle pulse on a CPU write to the ROM region

Behaviour:
- Reset (b_rst=0, async): RAM/SRAM/ioreg cleared to 0; ROM retained. cpu_rdy=1, oam_wen=0, oam_waddr=0, oam_wdata=0, rom_wr_err=0, strobe=0, shift regs=0, DMA state IDLE, parity=0.
- Decode on cpu_addr[15:13]: 000 RAM (addr[RAM_AW-1:0]); 001 ioreg (addr[2:0], $2000-$3FFF mirrored); 010 OTHER; 011 SRAM; 1xx ROM.
- Vectors $FFFA-$FFFF are returned from ROM contents, not hardwired.
- Writes take effect at the clock edge; a read in the next cycle returns the new value.
- Unmapped OTHER reads return 8'h00; unmapped OTHER writes are ignored.
- ROM write: storage unchanged; rom_wr_err=1 for exactly that cycle.
- Parity: 1-bit counter toggling every clk from reset.
- DMA FSM states: IDLE, ALIGN, ALIGN2, RD, WR.
  - A CPU write of P to $4014 in IDLE latches page P and byte counter i=0, then goes to ALIGN.
  - ALIGN->ALIGN2 if the parity at the trigger edge was odd, else ALIGN->RD.
  - ALIGN2->RD.
  - RD reads the internal map at {P,i} into a holding register, then ->WR.
  - WR drives oam_wen=1, oam_waddr=i, oam_wdata=held byte, then i++. Goes ->RD, or ->IDLE after i=DMA_LEN-1.
  - cpu_rdy=0 in every non-IDLE state and returns to 1 in the cycle IDLE is re-entered.
  - Total stall = 2*DMA_LEN+1 cycles (even trigger) or +2 (odd trigger).
- DMA source pages: $00-$1F RAM (mirrored), $60-$7F SRAM, $80-$FF ROM; all other pages read 8'h00.
- CPU ren/wen while cpu_rdy=0 are ignored: no write, no joypad shift, no rom_wr_err.
- Joypad strobe: a write to $4016 sets strobe=cpu_wdata[0] for all pads.
  - While strobe=1, each shift reg reloads from joy_buttons every cycle.
  - On the 1->0 transition, the last loaded value is held.
- Joypad read of pad n: cpu_rdata = 8'h40 | {7'b0, sr_n[0]}.
  - If strobe=0, sr_n shifts right at the edge, filling 1.
  - After 8 reads, further reads return 8'h41.
  - While strobe=1, reads return the live A bit with no shift.
  - With NUM_JOYPADS=1, $4017 reads 8'h40.
- Writes to $4017 are ignored.
- rom_ld_en writes ROM at the edge (also while b_rst=0); it is ignored while DMA is active.
- Reset mid-DMA aborts: state IDLE, cpu_rdy=1, oam_wen=0.

Decomposition:
- mem_pkg additions: ADDR_OAM_DMA=16'h4014, ADDR_JOYPAD1/2, the region enum for addr[15:13], dma_state_t enum {IDLE, ALIGN, ALIGN2, RD, WR}, JOY_OPEN_BUS=8'h40.
- Sub-module nes_joypad_shift: one per pad, inputs strobe/load/shift/buttons, output serial bit; instantiated in a generate loop.

Test Plan:
- Write RAM $0005=8'hA5, read $0805 and $1805 -> both 8'hA5; write $8000 -> rom_wr_err pulses 1 cycle, ROM unchanged.
- Preload RAM $0200+i = i, write $4014=8'h02 on an even cycle -> cpu_rdy low 513 cycles, 256 oam_wen pulses with waddr=wdata=i, in order.
- Same DMA triggered on an odd cycle -> stall 514 cycles; a wen to $0000 during the stall leaves RAM unchanged.
- joy_buttons[7:0]=8'b1000_0101, write $4016=1 then 0, 10 reads of $4016 -> 41,40,41,40,40,40,40,41,41,41.
- Assert b_rst=0 at DMA byte 100 -> cpu_rdy=1 and oam_wen=0 immediately; RAM reads 0 after reset release; ROM contents retained.

Source files
------------

// File: rtl/nes_cpu_mem_ctrl_pkg.sv
// Shared constants and types for the NES CPU-side memory controller:
// register addresses, address-region decode and the sprite DMA state encoding.
package nes_cpu_mem_ctrl_pkg;

  localparam logic [15:0] ADDR_OAM_DMA = 16'h4014;
  localparam logic [15:0] ADDR_JOYPAD1 = 16'h4016;
  localparam logic [15:0] ADDR_JOYPAD2 = 16'h4017;
  localparam logic [7:0]  JOY_OPEN_BUS = 8'h40;

  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_IO,
    REGION_OTHER,
    REGION_SRAM,
    REGION_ROM
  } region_t;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_ALIGN,
    DMA_ALIGN2,
    DMA_RD,
    DMA_WR
  } dma_state_t;

  // Region select from cpu_addr[15:13]; the whole upper half is ROM.
  function automatic region_t decode_region(input logic [2:0] addr_hi);
    case (addr_hi)
      3'b000:  return REGION_RAM;
      3'b001:  return REGION_IO;
      3'b010:  return REGION_OTHER;
      3'b011:  return REGION_SRAM;
      default: return REGION_ROM;
    endcase
  endfunction

endpackage

// File: rtl/nes_joypad_shift.sv
// One serial joypad channel: parallel reload while strobed, shift-right with
// 1-fill on each read once the strobe is released.
module nes_joypad_shift (
  input  logic       clk,
  input  logic       b_rst,
  input  logic       strobe,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] buttons,
  output logic       serial
);

  logic [7:0] sr_q, sr_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sr_d = sr_q;
    if (load)       sr_d = buttons;
    else if (shift) sr_d = {1'b1, sr_q[7:1]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  // While strobed the pad reports the live A button rather than the last load.
  assign serial = strobe ? buttons[0] : sr_q[0];

endmodule

// File: rtl/nes_cpu_mem_ctrl.sv
// CPU-side memory map (ROM, mirrored RAM, SRAM, I/O regs) with sprite DMA to
// OAM and serial joypad emulation.
module nes_cpu_mem_ctrl
  import nes_cpu_mem_ctrl_pkg::*;
#(
  parameter int ROM_AW      = 15,
  parameter int RAM_AW      = 11,
  parameter int SRAM_AW     = 13,
  parameter int NUM_JOYPADS = 2,
  parameter int DMA_LEN     = 256
) (
  input  logic                     clk,
  input  logic                     b_rst,
  input  logic                     ren,
  input  logic                     wen,
  input  logic [15:0]              cpu_addr,
  input  logic [7:0]               cpu_wdata,
  output logic [7:0]               cpu_rdata,
  output logic                     cpu_rdy,
  output logic                     oam_wen,
  output logic [7:0]               oam_waddr,
  output logic [7:0]               oam_wdata,
  input  logic [8*NUM_JOYPADS-1:0] joy_buttons,
  input  logic                     rom_ld_en,
  input  logic [ROM_AW-1:0]        rom_ld_addr,
  input  logic [7:0]               rom_ld_data,
  output logic                     rom_wr_err
);

  localparam logic [7:0] DMA_LAST = 8'(DMA_LEN - 1);

  logic [7:0] rom_mem  [2**ROM_AW];
  logic [7:0] ram_mem  [2**RAM_AW];
  logic [7:0] sram_mem [2**SRAM_AW];
  logic [7:0] io_mem   [8];

  dma_state_t state_q, state_d;
  logic [7:0] page_q, page_d, idx_q, idx_d;
  logic       odd_q, odd_d, parity_q, parity_d, strobe_q, strobe_d;
  logic       cpu_rdy_q, cpu_rdy_d, oam_wen_q, oam_wen_d, rom_wr_err_q, rom_wr_err_d;
  logic [7:0] oam_waddr_q, oam_waddr_d, oam_wdata_q, oam_wdata_d;

  // CPU accesses are only honoured while the DMA engine is idle.
  logic    cpu_we, cpu_re;
  region_t cpu_region, dma_region;
  logic [15:0] dma_addr;
  logic [7:0]  dma_byte;
  logic [1:0]  joy_bit;

  assign cpu_we     = wen && cpu_rdy_q;
  assign cpu_re     = ren && cpu_rdy_q;
  assign cpu_region = decode_region(cpu_addr[15:13]);
  assign dma_addr   = {page_q, idx_q};
  assign dma_region = decode_region(dma_addr[15:13]);

  for (genvar n = 0; n < 2; n++) begin : g_pad
    if (n < NUM_JOYPADS) begin : g_on
      nes_joypad_shift u_pad (
        .clk     (clk),
        .b_rst   (b_rst),
        .strobe  (strobe_q),
        .load    (strobe_q),
        .shift   (cpu_re && (cpu_addr == ADDR_JOYPAD1 + 16'(n))),
        .buttons (joy_buttons[8*n +: 8]),
        .serial  (joy_bit[n])
      );
    end else begin : g_off
      assign joy_bit[n] = 1'b0;
    end
  end

  // NOTE: ROM has no reset so preloaded contents survive b_rst; the RAM-like arrays below are cleared.
  always_ff @(posedge clk) begin
    if (rom_ld_en && state_q == DMA_IDLE) rom_mem[rom_ld_addr] <= rom_ld_data;
  end

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      for (int k = 0; k < 2**RAM_AW; k++)  ram_mem[k]  <= '0;
      for (int k = 0; k < 2**SRAM_AW; k++) sram_mem[k] <= '0;
      for (int k = 0; k < 8; k++)          io_mem[k]   <= '0;
    end else if (cpu_we) begin
      case (cpu_region)
        REGION_RAM:  ram_mem[cpu_addr[RAM_AW-1:0]]   <= cpu_wdata;
        REGION_IO:   io_mem[cpu_addr[2:0]]           <= cpu_wdata;
        REGION_SRAM: sram_mem[cpu_addr[SRAM_AW-1:0]] <= cpu_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_rdata = '0;
    case (cpu_region)
      REGION_RAM:  cpu_rdata = ram_mem[cpu_addr[RAM_AW-1:0]];
      REGION_IO:   cpu_rdata = io_mem[cpu_addr[2:0]];
      REGION_SRAM: cpu_rdata = sram_mem[cpu_addr[SRAM_AW-1:0]];
      REGION_ROM:  cpu_rdata = rom_mem[cpu_addr[ROM_AW-1:0]];
      default: begin
        if (cpu_addr == ADDR_JOYPAD1)      cpu_rdata = JOY_OPEN_BUS | {7'b0, joy_bit[0]};
        else if (cpu_addr == ADDR_JOYPAD2) cpu_rdata = JOY_OPEN_BUS | {7'b0, joy_bit[1]};
      end
    endcase
  end

  // DMA sees RAM, SRAM and ROM only; I/O and unmapped pages read as zero.
  always_comb begin
    dma_byte = '0;
    case (dma_region)
      REGION_RAM:  dma_byte = ram_mem[dma_addr[RAM_AW-1:0]];
      REGION_SRAM: dma_byte = sram_mem[dma_addr[SRAM_AW-1:0]];
      REGION_ROM:  dma_byte = rom_mem[dma_addr[ROM_AW-1:0]];
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    idx_d        = idx_q;
    odd_d        = odd_q;
    parity_d     = ~parity_q;
    oam_wen_d    = 1'b0;
    oam_waddr_d  = oam_waddr_q;
    oam_wdata_d  = oam_wdata_q;
    strobe_d     = (cpu_we && cpu_addr == ADDR_JOYPAD1) ? cpu_wdata[0] : strobe_q;
    rom_wr_err_d = cpu_we && (cpu_region == REGION_ROM);
    case (state_q)
      DMA_IDLE: begin
        if (cpu_we && cpu_addr == ADDR_OAM_DMA) begin
          state_d = DMA_ALIGN;
          page_d  = cpu_wdata;
          idx_d   = '0;
          odd_d   = parity_q;
        end
      end
      DMA_ALIGN:  state_d = odd_q ? DMA_ALIGN2 : DMA_RD;
      DMA_ALIGN2: state_d = DMA_RD;
      DMA_RD: begin
        // The OAM output registers double as the holding register for the WR cycle.
        state_d     = DMA_WR;
        oam_wen_d   = 1'b1;
        oam_waddr_d = idx_q;
        oam_wdata_d = dma_byte;
      end
      DMA_WR: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == DMA_LAST) ? DMA_IDLE : DMA_RD;
      end
      default: state_d = DMA_IDLE;
    endcase
    cpu_rdy_d = (state_d == DMA_IDLE);
  end

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      state_q      <= DMA_IDLE;
      page_q       <= '0;
      idx_q        <= '0;
      odd_q        <= 1'b0;
      parity_q     <= 1'b0;
      strobe_q     <= 1'b0;
      cpu_rdy_q    <= 1'b1;
      oam_wen_q    <= 1'b0;
      oam_waddr_q  <= '0;
      oam_wdata_q  <= '0;
      rom_wr_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      idx_q        <= idx_d;
      odd_q        <= odd_d;
      parity_q     <= parity_d;
      strobe_q     <= strobe_d;
      cpu_rdy_q    <= cpu_rdy_d;
      oam_wen_q    <= oam_wen_d;
      oam_waddr_q  <= oam_waddr_d;
      oam_wdata_q  <= oam_wdata_d;
      rom_wr_err_q <= rom_wr_err_d;
    end
  end

  assign cpu_rdy    = cpu_rdy_q;
  assign oam_wen    = oam_wen_q;
  assign oam_waddr  = oam_waddr_q;
  assign oam_wdata  = oam_wdata_q;
  assign rom_wr_err = rom_wr_err_q;

endmodule
